dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and a slower line-wide backing memory. It replaces the single-cycle data memory on the CPU side. Hits are serviced in the access cycle with no stall. Misses assert stall_o, run an optional dirty-victim writeback and a line refill over a req/ack memory port, then service the held access.

---
 rtl/dcache_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_dcache_controller.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache
// sitting between the pipeline MEM stage and a line-wide backing memory.
// Hits are serviced combinationally in the access cycle; misses stall the
// pipeline while an optional dirty-victim writeback and a line refill run
// over a req/ack memory port, after which the held access completes.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   cpu_req_i/we_i/addr_i/  CPU access (held stable while stall_o = 1)
//   cpu_wdata_i
//   cpu_rdata_o             load data, valid on a hit cycle, else 0
//   stall_o                 pipeline freeze, combinational
//   mem_req_o/we_o/addr_o/  registered line request to backing memory
//   mem_wdata_o
//   mem_rdata_i, mem_ack_i  refill data and one-cycle completion pulse
//   hit_cnt_o, miss_cnt_o   saturating event counters
module dcache_controller #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_wdata_i,
    output logic [31:0]  cpu_rdata_o,
    output logic         stall_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [127:0] mem_wdata_o,
    input  logic [127:0] mem_rdata_i,
    input  logic         mem_ack_i,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
);

    localparam int unsigned INDEX_W = $clog2(LINES);
    localparam int unsigned OFF_W   = 2;
    localparam int unsigned TAG_W   = 32 - 4 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Line storage: valid/dirty are reset, tag/data are plain arrays.
    logic [LINES-1:0]       valid_q;
    logic [LINES-1:0]       dirty_q;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [WORDS-1:0][31:0] data_q [LINES];

    // Registered memory-port outputs.
    logic         mem_req_q,   mem_req_d;
    logic         mem_we_q,    mem_we_d;
    logic [31:0]  mem_addr_q,  mem_addr_d;
    logic [127:0] mem_wdata_q, mem_wdata_d;

    // Missed access, latched so the refill does not depend on live inputs.
    logic [TAG_W-1:0]   lat_tag_q, lat_tag_d;
    logic [INDEX_W-1:0] lat_idx_q, lat_idx_d;

    logic        refill_done_q;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // CPU address decode.
    logic [OFF_W-1:0]   req_off_c;
    logic [INDEX_W-1:0] req_idx_c;
    logic [TAG_W-1:0]   req_tag_c;
    logic               unused_addr_c;

    assign req_off_c     = cpu_addr_i[3:2];
    assign req_idx_c     = cpu_addr_i[4 +: INDEX_W];
    assign req_tag_c     = cpu_addr_i[31 -: TAG_W];
    assign unused_addr_c = ^cpu_addr_i[1:0];

    logic hit_c;
    logic serve_c;
    logic miss_c;
    logic wb_done_c;
    logic fill_c;
    logic victim_dirty_c;

    assign hit_c          = cpu_req_i & valid_q[req_idx_c] & (tag_q[req_idx_c] == req_tag_c);
    assign serve_c        = (state_q == IDLE) & hit_c;
    assign victim_dirty_c = valid_q[req_idx_c] & dirty_q[req_idx_c];

    // CPU-facing outputs are combinational so hits complete with zero latency.
    assign stall_o     = (state_q != IDLE) | (cpu_req_i & ~hit_c);
    assign cpu_rdata_o = serve_c ? data_q[req_idx_c][req_off_c] : 32'h0;

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign hit_cnt_o   = hit_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;

    // Next-state and memory-port request logic.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        lat_tag_d   = lat_tag_q;
        lat_idx_d   = lat_idx_q;
        miss_c      = 1'b0;
        wb_done_c   = 1'b0;
        fill_c      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req_i && !hit_c) begin
                    miss_c    = 1'b1;
                    lat_tag_d = req_tag_c;
                    lat_idx_d = req_idx_c;
                    mem_req_d = 1'b1;
                    if (victim_dirty_c) begin
                        state_d     = WRITEBACK;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[req_idx_c], req_idx_c, 4'h0};
                        mem_wdata_d = data_q[req_idx_c];
                    end else begin
                        state_d    = ALLOCATE;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_tag_c, req_idx_c, 4'h0};
                    end
                end
            end
            WRITEBACK: begin
                // Request stays up across the transition; only the command changes.
                if (mem_ack_i) begin
                    wb_done_c  = 1'b1;
                    state_d    = ALLOCATE;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {lat_tag_q, lat_idx_q, 4'h0};
                end
            end
            ALLOCATE: begin
                if (mem_ack_i) begin
                    fill_c    = 1'b1;
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State, control bits, port registers and counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            dirty_q       <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_wdata_q   <= 128'h0;
            lat_tag_q     <= '0;
            lat_idx_q     <= '0;
            refill_done_q <= 1'b0;
            hit_cnt_q     <= 32'h0;
            miss_cnt_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lat_tag_q   <= lat_tag_d;
            lat_idx_q   <= lat_idx_d;

            // The re-presented access after a refill is not a hit.
            if (serve_c && !refill_done_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_c && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end

            if (fill_c) begin
                refill_done_q <= 1'b1;
            end else if (serve_c) begin
                refill_done_q <= 1'b0;
            end

            if (serve_c && cpu_we_i) begin
                dirty_q[req_idx_c] <= 1'b1;
            end
            if (wb_done_c) begin
                dirty_q[lat_idx_q] <= 1'b0;
            end
            if (fill_c) begin
                valid_q[lat_idx_q] <= 1'b1;
                dirty_q[lat_idx_q] <= 1'b0;
            end
        end
    end

    // Tag/data arrays: refill writes a whole line, a store hit writes one word.
    always_ff @(posedge clk_i) begin
        if (fill_c) begin
            tag_q[lat_idx_q]  <= lat_tag_q;
            data_q[lat_idx_q] <= mem_rdata_i;
        end else if (serve_c && cpu_we_i) begin
            data_q[req_idx_c][req_off_c] <= cpu_wdata_i;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: a transaction-level model
// (CPU-visible memory image, backing memory image and per-index residency)
// predicts every cycle's outputs; directed cases pin the model with literals.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic [127:0] mem_rdata_i;
    logic         mem_ack_i;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    always #5 clk_i = ~clk_i;

    dcache_controller #(.LINES(16), .WORDS(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [127:0] golden  [int unsigned];   // what the CPU must observe
    logic [127:0] backing [int unsigned];   // what the memory side holds
    bit           m_valid [16];
    bit           m_dirty [16];
    logic [23:0]  m_tag   [16];

    function automatic logic [127:0] init_line(input int unsigned ln);
        logic [127:0] v;
        for (int i = 0; i < 4; i++) begin
            v[32*i +: 32] = (ln * 32'h9E37_79B1) ^ (32'(i) << 24) ^ 32'h5A5A_0000;
        end
        return v;
    endfunction

    function automatic logic [127:0] bget(input int unsigned ln);
        if (!backing.exists(ln)) backing[ln] = init_line(ln);
        return backing[ln];
    endfunction

    function automatic logic [127:0] gget(input int unsigned ln);
        if (!golden.exists(ln)) golden[ln] = bget(ln);
        return golden[ln];
    endfunction

    function automatic logic [31:0] gword(input logic [31:0] addr);
        logic [127:0] l;
        int w;
        l = gget(32'(addr[31:4]));
        w = int'(addr[3:2]);
        return l[32*w +: 32];
    endfunction

    function automatic void gput(input logic [31:0] addr, input logic [31:0] wd);
        logic [127:0] l;
        int w;
        l = gget(32'(addr[31:4]));
        w = int'(addr[3:2]);
        l[32*w +: 32] = wd;
        golden[32'(addr[31:4])] = l;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- expectations for the compare process ----------------
    bit           chk_en = 1'b0;
    bit           exp_stall, exp_req, exp_we, exp_rd_chk;
    logic [31:0]  exp_addr, exp_rdata;
    logic [127:0] exp_wdata;
    logic [31:0]  exp_hits, exp_misses;

    // Observations, written only by the compare process.
    int           stall_cyc = 0;
    int           wb_cyc = 0;
    int           rf_cyc = 0;
    logic [31:0]  obs_rdata = 32'h0;
    logic [31:0]  obs_wb_addr = 32'h0;
    logic [31:0]  obs_rf_addr = 32'h0;
    logic [127:0] obs_wb_data = 128'h0;

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("stall_o", 128'(stall_o), 128'(exp_stall));
            chk("mem_req_o", 128'(mem_req_o), 128'(exp_req));
            if (exp_req) begin
                chk("mem_we_o", 128'(mem_we_o), 128'(exp_we));
                chk("mem_addr_o", 128'(mem_addr_o), 128'(exp_addr));
                if (exp_we) chk("mem_wdata_o", mem_wdata_o, exp_wdata);
            end
            if (!cpu_req_i) chk("cpu_rdata_o_idle", 128'(cpu_rdata_o), 128'h0);
            else if (exp_rd_chk) chk("cpu_rdata_o", 128'(cpu_rdata_o), 128'(exp_rdata));
            chk("hit_cnt_o", 128'(hit_cnt_o), 128'(exp_hits));
            chk("miss_cnt_o", 128'(miss_cnt_o), 128'(exp_misses));
        end
        if (stall_o) stall_cyc++;
        if (mem_req_o && mem_we_o) begin
            wb_cyc++;
            obs_wb_addr = mem_addr_o;
            obs_wb_data = mem_wdata_o;
        end
        if (mem_req_o && !mem_we_o) begin
            rf_cyc++;
            obs_rf_addr = mem_addr_o;
        end
        if (cpu_req_i && !stall_o) obs_rdata = cpu_rdata_o;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n, input bit stray);
        cpu_req_i  = 1'b0;
        exp_stall  = 1'b0;
        exp_req    = 1'b0;
        exp_rd_chk = 1'b0;
        for (int c = 0; c < n; c++) begin
            cpu_we_i    = 1'($urandom);
            cpu_addr_i  = $urandom;
            cpu_wdata_i = $urandom;
            mem_ack_i   = stray ? 1'($urandom) : 1'b0;
            mem_rdata_i = rnd128();
            step();
        end
        mem_ack_i = 1'b0;
    endtask

    // One CPU access, with the memory answering on cycle lwb/lal of each request.
    task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                             input int lwb, input int lal);
        int unsigned ln, vln;
        int          idx;
        logic [23:0] tg;
        ln  = 32'(addr[31:4]);
        idx = int'(addr[7:4]);
        tg  = addr[31:8];
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wd;
        mem_ack_i   = 1'b0;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            exp_stall  = 1'b0;
            exp_req    = 1'b0;
            exp_rd_chk = !we;
            exp_rdata  = gword(addr);
            step();
            if (we) begin
                gput(addr, wd);
                m_dirty[idx] = 1'b1;
            end
            if (exp_hits != 32'hFFFF_FFFF) exp_hits++;
        end else begin
            exp_stall  = 1'b1;
            exp_req    = 1'b0;
            exp_rd_chk = 1'b0;
            step();
            if (exp_misses != 32'hFFFF_FFFF) exp_misses++;
            if (m_valid[idx] && m_dirty[idx]) begin
                vln       = {4'h0, m_tag[idx], 4'(idx)};
                exp_req   = 1'b1;
                exp_we    = 1'b1;
                exp_addr  = {m_tag[idx], 4'(idx), 4'h0};
                exp_wdata = gget(vln);
                for (int c = 1; c <= lwb; c++) begin
                    mem_ack_i   = (c == lwb);
                    mem_rdata_i = rnd128();
                    step();
                end
                mem_ack_i     = 1'b0;
                backing[vln]  = gget(vln);
                m_dirty[idx]  = 1'b0;
            end
            exp_req  = 1'b1;
            exp_we   = 1'b0;
            exp_addr = {addr[31:4], 4'h0};
            for (int c = 1; c <= lal; c++) begin
                mem_ack_i   = (c == lal);
                mem_rdata_i = (c == lal) ? bget(ln) : rnd128();
                step();
            end
            mem_ack_i    = 1'b0;
            mem_rdata_i  = rnd128();
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
            exp_stall  = 1'b0;
            exp_req    = 1'b0;
            exp_rd_chk = !we;
            exp_rdata  = gword(addr);
            step();
            if (we) begin
                gput(addr, wd);
                m_dirty[idx] = 1'b1;
            end
        end
        exp_rd_chk = 1'b0;
        cpu_req_i  = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 24'h0;
        end
        // Dirty data still in the cache is lost on reset.
        foreach (golden[k]) golden[k] = backing[k];
        exp_hits   = 32'h0;
        exp_misses = 32'h0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          base_st, base_wb, base_mem;
        logic [23:0] rtag;
        logic [31:0] addr;

        rst_i       = 1'b1;
        cpu_req_i   = 1'b0;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'h0;
        cpu_wdata_i = 32'h0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 128'h0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_rd_chk = 1'b0;
        exp_addr = 32'h0; exp_rdata = 32'h0; exp_wdata = 128'h0;
        model_reset();

        // Reset state.
        #1 rst_i = 1'b0;
        #1;
        chk("rst_mem_req", 128'(mem_req_o), 128'h0);
        chk("rst_mem_we", 128'(mem_we_o), 128'h0);
        chk("rst_mem_addr", 128'(mem_addr_o), 128'h0);
        chk("rst_mem_wdata", mem_wdata_o, 128'h0);
        chk("rst_hit_cnt", 128'(hit_cnt_o), 128'h0);
        chk("rst_miss_cnt", 128'(miss_cnt_o), 128'h0);
        chk("rst_stall", 128'(stall_o), 128'h0);
        chk("rst_rdata", 128'(cpu_rdata_o), 128'h0);
        step();
        step();
        rst_i  = 1'b1;
        chk_en = 1'b1;

        // Idle.
        idle(10, 1'b0);
        chk("idle_hit_cnt", 128'(hit_cnt_o), 128'h0);
        chk("idle_miss_cnt", 128'(miss_cnt_o), 128'h0);

        // Cold read miss at 0x100, ack on the 3rd ALLOCATE cycle.
        backing[32'h10] = {32'hD, 32'hC, 32'hB, 32'hA};
        golden[32'h10]  = {32'hD, 32'hC, 32'hB, 32'hA};
        base_st = stall_cyc;
        do_access(1'b0, 32'h100, 32'h0, 1, 3);
        chk("cold_stall_cycles", 128'(stall_cyc - base_st), 128'd4);
        chk("cold_refill_addr", 128'(obs_rf_addr), 128'h100);
        chk("cold_rdata", 128'(obs_rdata), 128'hA);

        base_st = stall_cyc;
        do_access(1'b0, 32'h104, 32'h0, 1, 1);
        chk("hit_rdata", 128'(obs_rdata), 128'hB);
        chk("hit_no_stall", 128'(stall_cyc - base_st), 128'd0);
        chk("hit_cnt_1", 128'(hit_cnt_o), 128'd1);
        chk("miss_cnt_1", 128'(miss_cnt_o), 128'd1);

        // Write hit then read back.
        base_mem = wb_cyc + rf_cyc;
        do_access(1'b1, 32'h108, 32'hDEAD_BEEF, 1, 1);
        chk("wr_hit_no_mem", 128'(wb_cyc + rf_cyc - base_mem), 128'd0);
        do_access(1'b0, 32'h108, 32'h0, 1, 1);
        chk("wr_hit_readback", 128'(obs_rdata), 128'hDEAD_BEEF);

        // Dirty conflict at index 0.
        do_access(1'b0, 32'h200, 32'h0, 2, 2);
        chk("wb_addr", 128'(obs_wb_addr), 128'h100);
        chk("wb_data", obs_wb_data, {32'hD, 32'hDEAD_BEEF, 32'hB, 32'hA});
        chk("wb_then_refill", 128'(obs_rf_addr), 128'h200);
        base_wb = wb_cyc;
        do_access(1'b0, 32'h100, 32'h0, 1, 1);
        chk("clean_reload_no_wb", 128'(wb_cyc - base_wb), 128'd0);
        chk("clean_reload_rdata", 128'(obs_rdata), 128'hA);

        // Reset in the middle of ALLOCATE; a late ack must be ignored.
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'h200;
        exp_stall   = 1'b1;
        exp_req     = 1'b0;
        step();
        exp_misses++;
        exp_req  = 1'b1;
        exp_we   = 1'b0;
        exp_addr = 32'h200;
        step();
        chk_en = 1'b0;
        rst_i  = 1'b0;
        #1;
        chk("rst_async_mem_req", 128'(mem_req_o), 128'h0);
        cpu_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        model_reset();
        chk("rst_mid_hit_cnt", 128'(hit_cnt_o), 128'h0);
        chk("rst_mid_miss_cnt", 128'(miss_cnt_o), 128'h0);
        exp_stall   = 1'b0;
        exp_req     = 1'b0;
        chk_en      = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = rnd128();
        step();
        mem_ack_i = 1'b0;
        idle(2, 1'b0);
        base_st = stall_cyc;
        do_access(1'b0, 32'h200, 32'h0, 1, 2);
        chk("post_rst_miss_again", 128'(miss_cnt_o), 128'd1);
        chk("post_rst_stall", 128'(stall_cyc - base_st), 128'd3);

        // Store miss to a clean line, then a conflicting load.
        base_wb = wb_cyc;
        do_access(1'b1, 32'h310, 32'h55, 1, 2);
        chk("st_miss_no_wb", 128'(wb_cyc - base_wb), 128'd0);
        do_access(1'b0, 32'h410, 32'h0, 3, 1);
        chk("st_miss_wb_addr", 128'(obs_wb_addr), 128'h310);
        chk("st_miss_wb_word0", 128'(obs_wb_data[31:0]), 128'h55);

        // Randomized traffic over a few tags to force conflicts.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rtag = 24'h000000;
                1:       rtag = 24'h000001;
                2:       rtag = 24'h000002;
                default: rtag = 24'hFFFFFF;
            endcase
            addr = {rtag, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            do_access(1'($urandom_range(0, 1)), addr, $urandom,
                      int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 1'b1);
        end
        idle(2, 1'b0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
